npc_seq_ctrl: RTL and testbench



---
 rtl/npc_pkg.sv | 30 +++
 rtl/npc_perf_cnt.sv | 41 ++++
 rtl/npc_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_npc_seq_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npc_pkg
// Description : Shared constants for the NPC sequencer: state encoding,
//               halt-cause codes, ebreak encoding and XLEN/reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package npc_pkg;

    localparam int c_XLEN = 64;
    localparam logic [c_XLEN-1:0] c_RESET_PC = 64'h8000_0000;

    // Sequencer state encoding (visible on state_o)
    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_DECODE = 3'd2;
    localparam logic [2:0] c_S_EXEC   = 3'd3;
    localparam logic [2:0] c_S_WB     = 3'd4;
    localparam logic [2:0] c_S_HALT   = 3'd5;

    // Halt cause codes
    localparam logic [1:0] c_HC_NONE    = 2'd0;
    localparam logic [1:0] c_HC_EBREAK  = 2'd1;
    localparam logic [1:0] c_HC_ILLEGAL = 2'd2;
    localparam logic [1:0] c_HC_TIMEOUT = 2'd3;

    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;

endpackage
`default_nettype wire

// File: rtl/npc_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : npc_perf_cnt
// Description : Cycle and retired-instruction counters for the NPC core.
//               Both wrap silently modulo 2^CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_perf_cnt #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cyc_en,
    input  logic             i_ret_inc,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt
);

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;

    // Count active cycles and retirements; reset clears both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (i_cyc_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if (i_ret_inc) begin
                r_instret_cnt <= r_instret_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: rtl/npc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : npc_seq_ctrl
// Description : Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the NPC core.
//               Owns the PC, fetch timeout and sticky halt; all outputs are
//               registered or decoded from the state register only.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_seq_ctrl
    import npc_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC      = c_RESET_PC,
    parameter int                FETCH_TIMEOUT = 16,
    parameter int                CNT_W         = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop_req,
    output logic              imem_req,
    output logic [c_XLEN-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    input  logic              dec_legal,
    input  logic              dec_reg_wr,
    input  logic [4:0]        dec_rd,
    output logic              exu_en,
    output logic              rf_wen,
    output logic [c_XLEN-1:0] pc,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    // Last FETCH wait-count value allowed before the fetch is declared dead
    localparam logic [7:0] c_WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic [c_XLEN-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [7:0]        r_wait;
    logic              r_rf_wen;
    logic              w_cyc_en;
    logic              w_retire;

    // Next-state and halt-cause selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_FETCH;
                end
            end
            c_S_FETCH: begin
                // A response on the final allowed cycle beats the timeout
                if (imem_rvalid) begin
                    w_state_nxt = c_S_DECODE;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_nxt = c_S_HALT;
                    w_cause_nxt = c_HC_TIMEOUT;
                end
            end
            c_S_DECODE: begin
                // ebreak is not a legal decoder op, so it must be checked first
                if (r_inst == c_INST_EBREAK) begin
                    w_state_nxt = c_S_HALT;
                    w_cause_nxt = c_HC_EBREAK;
                end else if (!dec_legal) begin
                    w_state_nxt = c_S_HALT;
                    w_cause_nxt = c_HC_ILLEGAL;
                end else begin
                    w_state_nxt = c_S_EXEC;
                end
            end
            c_S_EXEC: begin
                w_state_nxt = c_S_WB;
            end
            c_S_WB: begin
                w_state_nxt = stop_req ? c_S_IDLE : c_S_FETCH;
            end
            c_S_HALT: begin
                w_state_nxt = c_S_HALT;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State, PC, instruction latch, fetch wait counter and registered rf_wen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_cause  <= c_HC_NONE;
            r_pc     <= RESET_PC;
            r_inst   <= 32'h0;
            r_wait   <= 8'd0;
            r_rf_wen <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cause <= w_cause_nxt;
            // Decoder outputs are stable in EXEC, so the WB-cycle enable is
            // captured one cycle early to keep rf_wen registered
            r_rf_wen <= (r_state == c_S_EXEC) && dec_reg_wr && (dec_rd != 5'd0);
            if ((r_state == c_S_FETCH) && imem_rvalid) begin
                r_inst <= imem_rdata;
            end
            if (r_state == c_S_WB) begin
                r_pc <= r_pc + 64'd4;
            end
            // Held at zero outside FETCH so every FETCH entry starts from zero
            if (r_state != c_S_FETCH) begin
                r_wait <= 8'd0;
            end else if (!imem_rvalid) begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    assign w_cyc_en = (r_state != c_S_IDLE) && (r_state != c_S_HALT);
    assign w_retire = (r_state == c_S_WB);

    npc_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_cyc_en      (w_cyc_en),
        .i_ret_inc     (w_retire),
        .o_cycle_cnt   (cycle_cnt),
        .o_instret_cnt (instret_cnt)
    );

    assign imem_req   = (r_state == c_S_FETCH);
    assign imem_addr  = r_pc;
    assign inst       = r_inst;
    assign exu_en     = (r_state == c_S_EXEC);
    assign rf_wen     = r_rf_wen;
    assign pc         = r_pc;
    assign state_o    = r_state;
    assign halted     = (r_state == c_S_HALT);
    assign halt_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_npc_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_npc_seq_ctrl
// Description : Self-checking bench for npc_seq_ctrl: directed programs, a
//               memory responder with per-word latency, a cycle model and a
//               per-cycle compare, plus hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_npc_seq_ctrl;

    localparam int          FETCH_TIMEOUT = 16;
    localparam logic [63:0] RESET_PC      = 64'h8000_0000;
    localparam logic [31:0] W_ADDI1  = 32'h0010_0093;
    localparam logic [31:0] W_ADDI0  = 32'h0050_0013;
    localparam logic [31:0] W_EBREAK = 32'h0010_0073;
    localparam logic [31:0] W_BAD    = 32'hFFFF_FFFF;
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_WB = 4, P_HALT = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, stop_req;
    logic        imem_req, imem_rvalid;
    logic [63:0] imem_addr, pc;
    logic [31:0] imem_rdata, inst;
    logic        dec_legal, dec_reg_wr;
    logic [4:0]  dec_rd;
    logic        exu_en, rf_wen, halted;
    logic [2:0]  state_o;
    logic [1:0]  halt_cause;
    logic [63:0] cycle_cnt, instret_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    npc_seq_ctrl #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .CNT_W         (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop_req    (stop_req),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .dec_legal   (dec_legal),
        .dec_reg_wr  (dec_reg_wr),
        .dec_rd      (dec_rd),
        .exu_en      (exu_en),
        .rf_wen      (rf_wen),
        .pc          (pc),
        .state_o     (state_o),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    // Toy decoder: OP-IMM is the only legal class; it always writes rd
    function automatic bit is_legal(input logic [31:0] w);
        return (w[6:0] == 7'h13);
    endfunction
    assign dec_legal  = is_legal(inst);
    assign dec_reg_wr = dec_legal;
    assign dec_rd     = inst[11:7];

    // Instruction memory: word and latency (wait cycles; 255 = never) per slot
    logic [31:0] prog [0:7];
    int          lat  [0:7];
    int          rcnt = 0;
    logic        resp_v = 1'b0;
    logic [31:0] resp_d = 32'h0;
    logic        man_v  = 1'b0;
    logic [31:0] man_d  = 32'h0;
    logic [63:0] off;
    logic [2:0]  idx;

    assign imem_rvalid = resp_v | man_v;
    assign imem_rdata  = man_v ? man_d : resp_d;

    // Responder: answer after lat[] request cycles at the requested slot
    always @(negedge clk) begin
        off = imem_addr - RESET_PC;
        idx = off[4:2];
        if (imem_req === 1'b1) begin
            resp_v = (rcnt == lat[idx]);
            resp_d = prog[idx];
            rcnt   = rcnt + 1;
        end else begin
            rcnt   = 0;
            resp_v = 1'b0;
            resp_d = 32'h0;
        end
    end

    // ---------------- behavioural model ----------------
    int          m_phase;
    int          m_wait;
    logic [63:0] m_pc, m_cyc, m_ret;
    logic [31:0] m_inst;
    logic [1:0]  m_cause;
    logic        m_rfwen;

    task automatic model_step();
        if (!rst_n) begin
            m_phase = P_IDLE; m_wait = 0; m_pc = RESET_PC; m_inst = 32'h0;
            m_cause = 2'd0; m_cyc = 64'd0; m_ret = 64'd0; m_rfwen = 1'b0;
        end else begin
            m_rfwen = 1'b0;
            if (m_phase != P_IDLE && m_phase != P_HALT) m_cyc = m_cyc + 1;
            case (m_phase)
                P_IDLE:   if (start) begin m_phase = P_FETCH; m_wait = 0; end
                P_FETCH: begin
                    if (imem_rvalid) begin
                        m_inst = imem_rdata; m_phase = P_DECODE;
                    end else if (m_wait + 1 >= FETCH_TIMEOUT) begin
                        m_phase = P_HALT; m_cause = 2'd3;
                    end else begin
                        m_wait = m_wait + 1;
                    end
                end
                P_DECODE: begin
                    if (m_inst == W_EBREAK)   begin m_phase = P_HALT; m_cause = 2'd1; end
                    else if (!is_legal(m_inst)) begin m_phase = P_HALT; m_cause = 2'd2; end
                    else m_phase = P_EXEC;
                end
                P_EXEC: begin
                    m_rfwen = is_legal(m_inst) && (m_inst[11:7] != 5'd0);
                    m_phase = P_WB;
                end
                P_WB: begin
                    m_pc  = m_pc + 64'd4;
                    m_ret = m_ret + 1;
                    m_wait = 0;
                    m_phase = stop_req ? P_IDLE : P_FETCH;
                end
                default: m_phase = P_HALT;
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state_o",     64'(state_o),     64'(m_phase));
            chk("pc",          pc,               m_pc);
            chk("imem_addr",   imem_addr,        m_pc);
            chk("imem_req",    64'(imem_req),    64'(m_phase == P_FETCH));
            chk("inst",        64'(inst),        64'(m_inst));
            chk("exu_en",      64'(exu_en),      64'(m_phase == P_EXEC));
            chk("rf_wen",      64'(rf_wen),      64'(m_rfwen));
            chk("halted",      64'(halted),      64'(m_phase == P_HALT));
            chk("halt_cause",  64'(halt_cause),  64'(m_cause));
            chk("cycle_cnt",   cycle_cnt,        m_cyc);
            chk("instret_cnt", instret_cnt,      m_ret);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; man_v = 1'b0;
        tick(2);
        chk_en = 1'b1;
        rst_n = 1'b1;
    endtask

    // Pulse start; returns at the negedge of FETCH cycle 1
    task automatic kick();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic load(input int i, input logic [31:0] w, input int l);
        prog[i] = w;
        lat[i]  = l;
    endtask

    initial begin
        int          nreq, nexu, nwen;
        logic [15:0] wen_mask;
        for (int i = 0; i < 8; i++) load(i, W_ADDI1, 0);
        rst_n = 1'b0; start = 1'b0; stop_req = 1'b0;

        // Reset state and addi stream
        do_reset();
        chk("rst_pc", pc, RESET_PC);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_cycle", cycle_cnt, 64'd0);
        load(3, W_ADDI0, 3);
        kick();
        wen_mask = 16'h0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick(1);
            if (rf_wen === 1'b1) wen_mask[k] = 1'b1;
            if (k == 4) chk("pc_i1", pc, 64'h8000_0000);
            if (k == 5) chk("pc_i2", pc, 64'h8000_0004);
            if (k == 9) chk("pc_i3", pc, 64'h8000_0008);
            if (k == 11) stop_req = 1'b1;
        end
        tick(1);
        stop_req = 1'b0;
        chk("wen_cycles", 64'(wen_mask), 64'h1110);
        chk("stop_idle", 64'(state_o), 64'd0);
        chk("stop_pc", pc, 64'h8000_000C);
        chk("cycle_12", cycle_cnt, 64'd12);
        chk("instret_3", instret_cnt, 64'd3);
        tick(3);
        chk("cycle_frozen", cycle_cnt, 64'd12);

        // Resume: x0 write with 3 wait states
        kick();
        nreq = 0; nexu = 0; nwen = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) tick(1);
            nreq += int'(imem_req); nexu += int'(exu_en); nwen += int'(rf_wen);
            if (k == 6) stop_req = 1'b1;
        end
        tick(1);
        stop_req = 1'b0;
        chk("ws_req_cycles", 64'(nreq), 64'd4);
        chk("x0_exu_pulses", 64'(nexu), 64'd1);
        chk("x0_rf_wen", 64'(nwen), 64'd0);
        chk("x0_pc", pc, 64'h8000_0010);
        chk("x0_instret", instret_cnt, 64'd4);
        chk("ws_cycle", cycle_cnt, 64'd19);

        // Ebreak halts at DECODE; start ignored; reset recovers
        load(3, W_ADDI1, 0);
        do_reset();
        load(1, W_EBREAK, 0);
        kick();
        tick(8);
        chk("eb_state", 64'(state_o), 64'd5);
        chk("eb_cause", 64'(halt_cause), 64'd1);
        chk("eb_pc", pc, 64'h8000_0004);
        chk("eb_halted", 64'(halted), 64'd1);
        start = 1'b1; tick(2); start = 1'b0; tick(1);
        chk("eb_sticky", 64'(state_o), 64'd5);
        do_reset();
        chk("eb_rst_pc", pc, RESET_PC);
        chk("eb_rst_halted", 64'(halted), 64'd0);
        load(1, W_ADDI1, 0);

        // Illegal instruction
        load(0, W_BAD, 0);
        kick();
        tick(4);
        chk("ill_cause", 64'(halt_cause), 64'd2);
        chk("ill_pc", pc, RESET_PC);
        chk("ill_inst", 64'(inst), 64'(W_BAD));

        // Fetch timeout after 16 FETCH cycles
        do_reset();
        load(0, W_ADDI1, 255);
        kick();
        nreq = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) tick(1);
            nreq += int'(imem_req);
        end
        chk("to_req_cycles", 64'(nreq), 64'd16);
        chk("to_cause", 64'(halt_cause), 64'd3);
        chk("to_pc", pc, RESET_PC);
        chk("to_cycle", cycle_cnt, 64'd16);

        // Response on the last allowed FETCH cycle wins
        do_reset();
        load(0, W_ADDI1, 15);
        kick();
        for (int k = 1; k <= 19; k++) begin
            if (k > 1) tick(1);
            if (k == 17) chk("late_decode", 64'(state_o), 64'd2);
            if (k == 18) stop_req = 1'b1;
        end
        tick(1);
        stop_req = 1'b0;
        chk("late_idle", 64'(state_o), 64'd0);
        chk("late_halted", 64'(halted), 64'd0);
        chk("late_pc", pc, 64'h8000_0004);
        chk("late_cycle", cycle_cnt, 64'd19);

        // Reset during FETCH; stale response arrives afterwards
        do_reset();
        load(0, W_ADDI1, 255);
        kick();
        tick(1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1; man_v = 1'b1; man_d = W_ADDI1;
        tick(1);
        man_v = 1'b0;
        chk("mr_state", 64'(state_o), 64'd0);
        chk("mr_inst", 64'(inst), 64'd0);
        tick(2);
        chk("mr_still_idle", 64'(state_o), 64'd0);
        chk("mr_instret", instret_cnt, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
